mips_irq_ctl: RTL

Interrupt acceptance stage between the device block's registered `irq_req_o`/`irq_addr_o` outputs and the CPU's PC-generation logic. It turns a level request into a single edge-triggered event and latches its vector. It presents the request to the pipeline with a stall-aware acknowledge handshake, saves the return PC, and blocks nesting until `eret`. Requests dropped while busy are counted for software diagnostics.

---
 rtl/mips_irq_ctl.sv | 113 +++++++++++
 1 files changed

// File: rtl/mips_irq_ctl.sv
// Interrupt acceptance: edge-detects irq_req_i, latches the vector, then a stall-aware ack saves epc and blocks nesting until eret.
// irq_o is valid the cycle after the edge; pipe_stall_i gates irq_o and the ack. Edges arriving while busy are dropped and counted.
module mips_irq_ctl #(
  parameter int HOLDOFF = 4,
  parameter int LOST_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              irq_req_i,
  input  logic [31:0]       irq_addr_i,
  input  logic              pipe_stall_i,
  input  logic              irq_ack_i,
  input  logic [31:0]       epc_i,
  input  logic              eret_i,
  input  logic              clr_lost_i,
  output logic              irq_o,
  output logic [31:0]       irq_vec_o,
  output logic [31:0]       epc_o,
  output logic              in_svc_o,
  output logic [LOST_W-1:0] lost_o
);

  localparam int HW = (HOLDOFF > 2) ? $clog2(HOLDOFF) : 1;
  localparam logic [HW-1:0] HCNT_LOAD = (HOLDOFF > 0) ? HW'(HOLDOFF - 1) : '0;
  localparam logic [LOST_W-1:0] LOST_MAX = {LOST_W{1'b1}};

  typedef enum logic [1:0] {IDLE, PEND, SVC, HOLD} state_t;

  state_t          state, state_nxt;
  logic            req_d;
  logic            edge_det;
  logic [HW-1:0]   hcnt, hcnt_nxt;
  logic            cap_vec, cap_epc, lost_inc;

  assign edge_det = irq_req_i & ~req_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    cap_vec   = 1'b0;
    cap_epc   = 1'b0;
    lost_inc  = 1'b0;
    irq_o     = 1'b0;
    in_svc_o  = 1'b0;
    case (state)
      IDLE: begin
        if (edge_det) begin
          cap_vec   = 1'b1;
          state_nxt = PEND;
        end
      end
      PEND: begin
        irq_o    = ~pipe_stall_i;
        lost_inc = edge_det;
        // An ack seen while stalled was not a real redirect, so it is ignored.
        if (irq_ack_i && !pipe_stall_i) begin
          cap_epc   = 1'b1;
          state_nxt = SVC;
        end
      end
      SVC: begin
        in_svc_o = 1'b1;
        lost_inc = edge_det;
        if (eret_i) begin
          if (HOLDOFF == 0) begin
            state_nxt = IDLE;
          end else begin
            hcnt_nxt  = HCNT_LOAD;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        lost_inc = edge_det;
        if (hcnt == '0) begin
          state_nxt = IDLE;
        end else begin
          hcnt_nxt = hcnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_d     <= 1'b0;
      hcnt      <= '0;
      irq_vec_o <= '0;
      epc_o     <= '0;
      lost_o    <= '0;
    end else begin
      req_d <= irq_req_i;
      hcnt  <= hcnt_nxt;
      if (cap_vec) irq_vec_o <= irq_addr_i;
      if (cap_epc) epc_o <= epc_i;
      if (clr_lost_i) begin
        lost_o <= '0;
      end else if (lost_inc && lost_o != LOST_MAX) begin
        lost_o <= lost_o + 1'b1;
      end
    end
  end

endmodule
